inst_fetch_unit: RTL

- Instruction fetch stage directly upstream of the instruction ROM driver.
- Generates the sequential PC and drives ROM chip-enable and address.
- Collects the registered ROM response into a small prefetch FIFO and presents {pc, inst} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding any in-flight response.

---
 rtl/inst_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single-outstanding ROM
// requests, prefetch FIFO to decode, and branch/jump redirect handling.
module inst_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_ce_o,
    output logic [ADDR_W-1:0]          rom_addr_o,
    input  logic [INST_W-1:0]          rom_inst_i,
    input  logic                       rom_ack_i,
    input  logic                       flush_i,
    input  logic [ADDR_W-1:0]          new_pc_i,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          pc_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     fifo_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              outstanding;
    logic              discard;

    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;

    logic              done;
    logic              kept;
    logic              can_issue;
    logic              push;
    logic              pop;
    logic [OW-1:0]     occ;
    logic [ADDR_W-1:0] target;

    assign done   = outstanding && rom_ack_i;
    assign kept   = outstanding && !rom_ack_i;
    assign target = new_pc_i & ALIGN;

    // The in-flight request owns a FIFO slot until it lands, so a
    // completing response can never find the FIFO full.
    assign occ = {1'b0, count} + OW'(outstanding);

    assign can_issue = rst
                     && !flush_i
                     && (!outstanding || rom_ack_i)
                     && (occ < OW'(DEPTH));

    assign valid_o = (count != '0);
    assign push    = done && !discard;
    assign pop     = valid_o && ready_i;

    assign rom_ce_o   = can_issue || kept;
    assign rom_addr_o = (kept ? req_pc : fetch_pc) & ALIGN;

    assign inst_o     = mem_inst[rptr];
    assign pc_o       = mem_pc[rptr];
    assign fifo_cnt_o = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else if (flush_i) begin
            // A still-pending request stays in flight but is marked stale.
            fetch_pc    <= target;
            outstanding <= kept;
            discard     <= kept;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
        end else begin
            if (can_issue) begin
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(4);
                outstanding <= 1'b1;
            end else if (done) begin
                outstanding <= 1'b0;
            end

            if (done && discard) begin
                discard <= 1'b0;
            end

            if (push) begin
                mem_pc[wptr]   <= req_pc;
                mem_inst[wptr] <= rom_inst_i;
                wptr           <= wptr + PW'(1);
            end

            if (pop) begin
                rptr <= rptr + PW'(1);
            end

            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
